// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the MEM stage (port 0) and the loader/debug port (port 1); round-robin when DMEM_ARB_RR_EN is defined, fixed priority (port 0 first) otherwise
module dmem_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              arb;
    logic              pick;
    logic              issue;
    logic              resp;
    assign arb   = (state_q != ISSUE) & (req0 | req1);
    assign issue = state_q == ISSUE;
    assign resp  = state_q == RESP;
`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;
    assign pick   = req1 & (~req0 | ~last_q);
    assign last_d = arb ? pick : last_q;
    // last-winner register; reset to port 1 so port 0 takes the first tie
    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`else
    assign pick = req1 & ~req0;
`endif
    // next state and request latch: ISSUE always moves to RESP, every other state arbitrates
    always_comb begin
        state_d = issue ? RESP : (arb ? ISSUE : IDLE);
        win_d   = arb ? pick : win_q;
        we_d    = arb ? (pick ? we1 : we0) : we_q;
        addr_d  = arb ? (pick ? addr1 : addr0) : addr_q;
        wdata_d = arb ? (pick ? wdata1 : wdata0) : wdata_q;
    end
    // state, winner and latched access registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    // outputs decoded from registered state only; read data passes through from the RAM's output register
    always_comb begin
        gnt0      = issue & ~win_q;
        gnt1      = issue & win_q;
        done0     = resp & ~win_q;
        done1     = resp & win_q;
        rdata0    = (done0 & ~we_q) ? mem_rdata : '0;
        rdata1    = (done1 & ~we_q) ? mem_rdata : '0;
        mem_en    = issue;
        mem_we    = issue & we_q;
        mem_addr  = issue ? addr_q : '0;
        mem_wdata = issue ? wdata_q : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against dmem_arbiter, checked every cycle by a transaction-level schedule model plus literal expectations
module tb_dmem_arbiter;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int N  = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, mem_en, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    function automatic logic [DW-1:0] init_val(int i);
        return (i == 5) ? 8'h3C : 8'(8'h10 + i);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // RAM behaves like the real registered-output single-port RAM
    logic [DW-1:0] ram [32];
    bit            ram_ld = 1'b0;
    always @(posedge clk) begin
        if (!ram_ld) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
            ram_ld <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // model: every non-issue cycle with a request schedules a grant one cycle later and a completion two cycles later
    bit            gv [N], gw [N], gwe [N], dv [N], dw [N];
    logic [AW-1:0] ga [N];
    logic [DW-1:0] gd [N], dr [N];
    logic [DW-1:0] ref_mem [32];
    int            cyc = 0;
    bit            last_w = 1'b1;
    bit            w;
    always @(posedge clk) begin
        if (cyc == 0) for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        if (reset) begin
            gv[cyc+1] = 1'b0;
            dv[cyc+1] = 1'b0;
            dv[cyc+2] = 1'b0;
            last_w = 1'b1;
        end else if (!gv[cyc] && (req0 || req1)) begin
`ifdef DMEM_ARB_RR_EN
            w = (req0 && req1) ? !last_w : req1;
`else
            w = (req0 && req1) ? 1'b0 : req1;
`endif
            last_w = w;
            gv[cyc+1]  = 1'b1;
            gw[cyc+1]  = w;
            gwe[cyc+1] = w ? we1 : we0;
            ga[cyc+1]  = w ? addr1 : addr0;
            gd[cyc+1]  = w ? wdata1 : wdata0;
            dv[cyc+2]  = 1'b1;
            dw[cyc+2]  = w;
            dr[cyc+2]  = gwe[cyc+1] ? 8'h00 : ref_mem[ga[cyc+1]];
            if (gwe[cyc+1]) ref_mem[ga[cyc+1]] = gd[cyc+1];
        end
        cyc = cyc + 1;
    end

    // compare every cycle once reset has been sampled
    int k;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            k = cyc;
            chk("gnt0", gnt0, gv[k] && !gw[k]);
            chk("gnt1", gnt1, gv[k] && gw[k]);
            chk("mem_en", mem_en, gv[k]);
            chk("mem_we", mem_we, gv[k] && gwe[k]);
            chk("mem_addr", mem_addr, gv[k] ? ga[k] : '0);
            chk("mem_wdata", mem_wdata, gv[k] ? gd[k] : '0);
            chk("done0", done0, dv[k] && !dw[k]);
            chk("done1", done1, dv[k] && dw[k]);
            chk("rdata0", rdata0, (dv[k] && !dw[k]) ? dr[k] : '0);
            chk("rdata1", rdata1, (dv[k] && dw[k]) ? dr[k] : '0);
        end
    end

    int seq [$];
    int n1;
    initial begin
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 req0 = 1'b1; we0 = 1'b0; addr0 = 5;
        @(negedge clk);
        chk("t1_gnt0", gnt0, 1); chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_addr", mem_addr, 5); chk("t1_mem_we", mem_we, 0);
        #2 req0 = 1'b0;
        @(negedge clk);
        chk("t1_done0", done0, 1); chk("t1_rdata0", rdata0, 8'h3C);
        @(negedge clk);
        chk("t1_idle", |{gnt0, gnt1, done0, done1, mem_en, mem_we, rdata0, rdata1, mem_addr, mem_wdata}, 0);
        #2 req1 = 1'b1; we1 = 1'b1; addr1 = 31; wdata1 = 8'hA5;
        @(negedge clk);
        chk("t2_gnt1", gnt1, 1); chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_wdata", mem_wdata, 8'hA5); chk("t2_mem_addr", mem_addr, 31);
        #2 req1 = 1'b0;
        @(negedge clk);
        chk("t2_wdone1", done1, 1); chk("t2_wrdata1", rdata1, 0);
        #2 req1 = 1'b1; we1 = 1'b0;
        @(negedge clk);
        chk("t2_rgnt1", gnt1, 1); chk("t2_rmem_we", mem_we, 0);
        #2 req1 = 1'b0;
        @(negedge clk);
        chk("t2_rdone1", done1, 1); chk("t2_rdata1", rdata1, 8'hA5);
        #2 req0 = 1'b1; we0 = 1'b0; addr0 = 2; req1 = 1'b1; we1 = 1'b0; addr1 = 9;
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gnt0) seq.push_back(0);
            if (gnt1) begin seq.push_back(1); n1++; end
        end
        chk("t3_ngnt", seq.size(), 4);
`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 4; i++) chk("t3_rr_seq", (i < seq.size()) ? seq[i] : -1, i % 2);
`else
        chk("t3_fp_gnt1_held", n1, 0);
`endif
        #2 req0 = 1'b0;
        @(negedge clk);
        chk("t3_gnt1_after_drop", gnt1, 1); chk("t3_addr9", mem_addr, 9);
        #2 req1 = 1'b0;
        @(negedge clk);
        chk("t3_done1", done1, 1); chk("t3_rdata1", rdata1, 8'h19);
        #2 req0 = 1'b1; we0 = 1'b0; addr0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_gnt0", gnt0, 1); chk("t4_mem_addr", mem_addr, i);
            #2 if (i == 2) req0 = 1'b0; else addr0 = AW'(i + 1);
            @(negedge clk);
            chk("t4_done0", done0, 1); chk("t4_rdata0", rdata0, 8'h10 + i);
        end
        #2 req0 = 1'b1; we0 = 1'b0; addr0 = 7;
        @(negedge clk);
        chk("t5_gnt0", gnt0, 1);
        #2 reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("t5_reset_outs", |{gnt0, gnt1, done0, done1, mem_en, mem_we, rdata0, rdata1, mem_addr, mem_wdata}, 0);
        #2 reset = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 3;
        @(negedge clk);
        chk("t5_gnt1", gnt1, 1); chk("t5_no_done0", done0, 0);
        #2 req1 = 1'b0;
        @(negedge clk);
        chk("t5_done1", done1, 1); chk("t5_rdata1", rdata1, 8'h13); chk("t5_no_done0b", done0, 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port synchronous data memory (MEM_LEN × DATA_SIZE bytes) between the CPU memory stage (port 0) and the data loader/debug port (port 1). It sits between the pipeline's MEM stage and the data RAM. It accepts one access per grant, drives the RAM for exactly one cycle, and returns a completion pulse with read data one cycle later. Arbitration is round-robin or fixed-priority, selected at compile time.

## Interface
- `DATA_W`, default `Def::DATA_SIZE` (8): data width.
- `ADDR_W`, default `Def::ADDR_SIZE` (5): byte address width.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req0` / `req1` in 1: access request from port 0 / port 1.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in ADDR_W: byte address.
- `wdata0` / `wdata1` in DATA_W: write data.
- `gnt0` / `gnt1` out 1: request captured; the memory access is issued this cycle.
- `done0` / `done1` out 1: access complete.
- `rdata0` / `rdata1` out DATA_W: read data, valid while the matching done is high.
- `mem_en` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, registered inside the RAM, valid the cycle after `mem_en`.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP. The state, winner ID, and latched we/addr/wdata are all registers.
- **IDLE:**
  - If any req is high, pick a winner, latch its we/addr/wdata and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - `gnt<w>`=1 and `mem_en`=1.
  - `mem_we`, `mem_addr` and `mem_wdata` come from the latched values.
  - Next state is RESP unconditionally. Reqs are ignored in this cycle.
- **RESP:**
  - `done<w>`=1.
  - On a read, `rdata<w>` = `mem_rdata`. On a write, `rdata<w>` = 0.
  - Arbitration runs again here: any req goes to ISSUE with a new latch, otherwise go to IDLE.
- **Requester rules:**
  - Hold req/we/addr/wdata stable until gnt is sampled high.
  - A req still high in the cycle after gnt is treated as a new request.
- The winner's non-granted peer sees gnt=0, done=0 and rdata=0.
- The address is used as-is. Full 2^ADDR_W range, no bounds check and no wrap logic.
- Reset values:
  - State IDLE.
  - All gnt, done, rdata, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are 0.
  - The round-robin last-winner register resets to 1, so port 0 wins the first tie.
- **Reset mid-operation:**
  - Reset is sampled at the edge. A RAM access driven during the reset-asserted cycle may still commit in the RAM.
  - The state returns to IDLE and no done pulse follows.
  - Reset in RESP suppresses nothing in that cycle: done stays visible until the edge.

## Timing
- Request to gnt: 1 cycle (req sampled in IDLE at cycle N, gnt in N+1).
- Request to done: 2 cycles (done in N+2).
- Back-to-back: a request sampled in RESP issues the next cycle. Sustained throughput is 1 access per 2 cycles.
- At most one of gnt0/gnt1 is high in any cycle; the same holds for done0/done1.
- `mem_en` is high only in ISSUE, one cycle per access.
- All outputs are registered or decoded from registered state only. There is no combinational path from req/addr to any output.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin.
  - On a tie, the port that did not win last time wins.
  - The last winner updates on every transition into ISSUE.
  - Neither port waits more than one access while holding req.
- `DMEM_ARB_RR_EN` undefined: fixed priority.
  - Port 0 always wins a tie.
  - Port 1 is served only when `req0`=0 in the arbitration cycle.
  - The last-winner register is not implemented.

## Test plan
- Read port 0:
  - Stimulus: RAM[5]=0x3C; `req0`=1, `we0`=0, `addr0`=5 at cycle 0, dropped after gnt.
  - Response: cycle 1 `gnt0`=1, `mem_en`=1, `mem_addr`=5, `mem_we`=0; cycle 2 `done0`=1, `rdata0`=0x3C; cycle 3 state IDLE with all outputs 0.
- Write then read, port 1:
  - Stimulus: write 0xA5 to address 31, then read address 31.
  - Response: the write issues `mem_we`=1, `mem_wdata`=0xA5, and its done pulse has `rdata1`=0; the read returns `rdata1`=0xA5.
- Contention, both reqs held continuously with distinct addresses:
  - With `DMEM_ARB_RR_EN`: grant sequence 0,1,0,1 with a gnt every 2 cycles.
  - Without `DMEM_ARB_RR_EN`: `gnt1` never rises while `req0` is held, and `gnt1` rises 1 cycle after `req0` drops in an arbitration cycle.
- Back-to-back: `req0` held with addresses 0,1,2 → `gnt0` in cycles 1, 3, 5 and `done0` in cycles 2, 4, 6 with matching data.
- Reset in ISSUE:
  - Stimulus: assert `reset` during the ISSUE cycle of a read.
  - Response: next cycle all outputs are 0 and the state is IDLE; no done is ever produced; a new `req1` afterwards is granted normally 1 cycle later.
